// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - playfield constants and paddle FSM state encodings shared by paddle, ball and collision logic
package pong_pkg;

  localparam int SCREEN_H = 480;
  localparam int PADDLE_H = 80;

  // Paddle Y is its top edge, so the lowest legal Y leaves the paddle fully on screen.
  localparam int PADDLE_POS_MIN  = 0;
  localparam int PADDLE_POS_MAX  = SCREEN_H - PADDLE_H;
  localparam int PADDLE_POS_INIT = PADDLE_POS_MAX / 2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MOVE_UP = 2'd1;
  localparam logic [1:0] MOVE_DN = 2'd2;

endpackage

// File: rtl/paddle_slew_tick.sv
// rtl/paddle_slew_tick.sv - free-running slew divider emitting a one-cycle tick every SLEW_DIV enabled clocks
module paddle_slew_tick #(
  parameter int SLEW_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(SLEW_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With SLEW_DIV == 1, LAST is 0 and the counter never leaves 0, so every enabled cycle ticks.
  assign tick = en && !clear && (cnt_q == LAST);

endmodule

// File: rtl/paddle_glide.sv
// rtl/paddle_glide.sv - paddle Y glide engine; define PADDLE_QUEUE_EN for a one-deep pending move command
module paddle_glide
  import pong_pkg::*;
#(
  parameter int POS_W    = 10,
  parameter int POS_MIN  = PADDLE_POS_MIN,
  parameter int POS_MAX  = PADDLE_POS_MAX,
  parameter int POS_INIT = PADDLE_POS_INIT,
  parameter int STEP     = 20,
  parameter int SLEW_DIV = 50000
) (
  input  logic             fingclock,
  input  logic             reset,
  input  logic             up_stb,
  input  logic             dn_stb,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             at_top,
  output logic             at_bottom
);

  localparam int REM_W = $clog2(STEP + 1);
  localparam logic [POS_W-1:0] MIN_P  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] MAX_P  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] INIT_P = POS_W'(POS_INIT);
  localparam logic [REM_W-1:0] STEP_R = REM_W'(STEP);
  localparam logic [REM_W-1:0] ONE_R  = REM_W'(1);

  logic [1:0]       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, next_pos;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             tick, done, take_v, take_up;

`ifdef PADDLE_QUEUE_EN
  logic pend_v_q, pend_v_d, pend_up_q, pend_up_d;
  logic valid_stb;
`endif

  paddle_slew_tick #(.SLEW_DIV(SLEW_DIV)) u_slew (
    .clk  (fingclock),
    .reset(reset),
    .clear(state_q == IDLE),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    rem_d    = rem_q;
    next_pos = pos_q;
    done     = 1'b0;
`ifdef PADDLE_QUEUE_EN
    // A strobe arriving on the completion edge counts as the pending command for that edge.
    valid_stb = up_stb ^ dn_stb;
    take_v    = pend_v_q || valid_stb;
    take_up   = pend_v_q ? pend_up_q : up_stb;
`else
    take_v  = 1'b0;
    take_up = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (up_stb && !dn_stb && pos_q != MIN_P) begin
          state_d = MOVE_UP;
          rem_d   = STEP_R;
        end else if (dn_stb && !up_stb && pos_q != MAX_P) begin
          state_d = MOVE_DN;
          rem_d   = STEP_R;
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (tick) begin
          next_pos = (state_q == MOVE_UP) ? pos_q - 1'b1 : pos_q + 1'b1;
          pos_d    = next_pos;
          rem_d    = rem_q - 1'b1;
          done     = (rem_q == ONE_R) ||
                     ((state_q == MOVE_UP) ? (next_pos == MIN_P) : (next_pos == MAX_P));
          if (done) begin
            state_d = IDLE;
            rem_d   = '0;
            if (take_v && take_up && next_pos != MIN_P) begin
              state_d = MOVE_UP;
              rem_d   = STEP_R;
            end else if (take_v && !take_up && next_pos != MAX_P) begin
              state_d = MOVE_DN;
              rem_d   = STEP_R;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
`ifdef PADDLE_QUEUE_EN
    pend_v_d  = pend_v_q;
    pend_up_d = pend_up_q;
    if (state_q != IDLE) begin
      if (done) begin
        pend_v_d = 1'b0;
      end else if (!pend_v_q && valid_stb) begin
        pend_v_d  = 1'b1;
        pend_up_d = up_stb;
      end
    end
`endif
  end

  always_ff @(posedge fingclock) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= INIT_P;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
    end
  end

`ifdef PADDLE_QUEUE_EN
  always_ff @(posedge fingclock) begin
    if (reset) begin
      pend_v_q  <= 1'b0;
      pend_up_q <= 1'b0;
    end else begin
      pend_v_q  <= pend_v_d;
      pend_up_q <= pend_up_d;
    end
  end
`endif

  assign pos       = pos_q;
  assign moving    = (state_q != IDLE);
  assign at_top    = (pos_q == MIN_P);
  assign at_bottom = (pos_q == MAX_P);

endmodule

// File: tb/tb_paddle_glide.sv
// tb/tb_paddle_glide.sv - directed vector bench for paddle_glide (small playfield, fast slew)
module tb_paddle_glide;

  localparam int POS_W    = 10;
  localparam int POS_MIN  = 0;
  localparam int POS_MAX  = 10;
  localparam int POS_INIT = 5;
  localparam int STEP     = 3;
  localparam int SLEW_DIV = 4;

  typedef struct packed {
    logic       rst;
    logic       up;
    logic       dn;
    logic [9:0] pos;
    logic       mv;
  } vec_t;

  logic             fingclock = 1'b0;
  logic             reset     = 1'b1;
  logic             up_stb    = 1'b0;
  logic             dn_stb    = 1'b0;
  logic [POS_W-1:0] pos;
  logic             moving, at_top, at_bottom;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  always #5 fingclock = ~fingclock;

  paddle_glide #(
    .POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX),
    .POS_INIT(POS_INIT), .STEP(STEP), .SLEW_DIV(SLEW_DIV)
  ) dut (
    .fingclock(fingclock),
    .reset    (reset),
    .up_stb   (up_stb),
    .dn_stb   (dn_stb),
    .pos      (pos),
    .moving   (moving),
    .at_top   (at_top),
    .at_bottom(at_bottom)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int p, input logic mv);
    chk({tag, ".pos"}, 32'(pos), 32'(p));
    chk({tag, ".moving"}, 32'(moving), 32'(mv));
    chk({tag, ".at_top"}, 32'(at_top), 32'(p == POS_MIN));
    chk({tag, ".at_bottom"}, 32'(at_bottom), 32'(p == POS_MAX));
  endtask

  // One active edge with the given inputs, then settle just after it.
  task automatic cyc(input logic r, input logic u, input logic d);
    reset  = r;
    up_stb = u;
    dn_stb = d;
    @(posedge fingclock);
    #1;
    reset  = 1'b0;
    up_stb = 1'b0;
    dn_stb = 1'b0;
  endtask

  function automatic void add(input logic r, input logic u, input logic d, input int p, input logic mv);
    vec_t v;
    v.rst = r; v.up = u; v.dn = d; v.pos = 10'(p); v.mv = mv;
    vecs.push_back(v);
  endfunction

  // Accept edge, then each pixel lands on the 4th edge after the previous one.
  function automatic void add_move(input logic u, input int start, input int npix);
    int cur;
    cur = start;
    add(1'b0, u, !u, cur, 1'b1);
    for (int i = 1; i <= npix; i++) begin
      for (int j = 0; j < SLEW_DIV - 1; j++) add(1'b0, 1'b0, 1'b0, cur, 1'b1);
      cur = u ? cur - 1 : cur + 1;
      add(1'b0, 1'b0, 1'b0, cur, (i == npix) ? 1'b0 : 1'b1);
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit q_en;
`ifdef PADDLE_QUEUE_EN
    q_en = 1'b1;
`else
    q_en = 1'b0;
`endif

    add(1, 0, 0, 5, 0);
    add(1, 0, 0, 5, 0);
    add(0, 0, 0, 5, 0);
    add(0, 1, 1, 5, 0);
    add(0, 0, 0, 5, 0);
    add_move(1, 5, 3);
    add_move(1, 2, 2);
    add(0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    add_move(0, 0, 3);
    add_move(0, 3, 3);
    add_move(0, 6, 3);
    add_move(0, 9, 1);
    add(0, 0, 1, 10, 0);
    add(0, 1, 1, 10, 0);
    add_move(1, 10, 3);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].up, vecs[i].dn);
      chk_out($sformatf("vec%0d", i), int'(vecs[i].pos), vecs[i].mv);
    end

    // Down glide with an up strobe mid-move.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk_out("midq.reset", 5, 0);
    cyc(0, 0, 1);
    chk_out("midq.e0", 5, 1);
    for (int k = 1; k <= 24; k++) begin
      cyc(0, k == 5, 0);
      if (k == 12) chk_out("midq.e12", 8, q_en);
      if (k == 16) chk_out("midq.e16", q_en ? 7 : 8, q_en);
      if (k == 24) chk_out("midq.e24", q_en ? 5 : 8, 0);
    end

    // Up strobe landing exactly on the completion edge.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, k == 12, 0);
      if (k == 12) chk_out("edgeq.e12", 8, q_en);
      if (k == 16) chk_out("edgeq.e16", q_en ? 7 : 8, q_en);
    end

    // Reset mid-glide abandons the move.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 0);
      if (k == 4) chk_out("rst.e4", 6, 1);
    end
    cyc(1, 0, 0);
    chk_out("rst.e6", 5, 0);
    for (int k = 0; k < 12; k++) cyc(0, 0, 0);
    chk_out("rst.after", 5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/paddle_glide.md
# paddle_glide

Paddle position engine for Pong: the consumer end of the rate-limited move strobes produced by the per-button movement limiters. Accepts one-cycle up/down strobes and glides the paddle STEP pixels per command, one pixel every SLEW_DIV clocks, saturating at the playfield bounds. Feeds the registered paddle Y coordinate to the renderer and the collision logic.

## Interface
- POS_W, 10, width of position bus
- POS_MIN, 0, top bound (smallest legal Y)
- POS_MAX, 400, bottom bound (largest legal Y)
- POS_INIT, 200, position after reset
- STEP, 20, pixels moved per accepted command
- SLEW_DIV, 50000, clocks per one-pixel step (>=1)
- fingclock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- up_stb  in  1  one-cycle move-up command (Y decreases)
- dn_stb  in  1  one-cycle move-down command (Y increases)
- pos  out  POS_W  current paddle Y, registered
- moving  out  1  high while a glide is in progress
- at_top  out  1  pos == POS_MIN
- at_bottom  out  1  pos == POS_MAX

## Operation
- Reset values: pos=POS_INIT, moving=0, at_top/at_bottom per POS_INIT, state IDLE, divider=0, remaining=0, pending cleared.
- States: IDLE, MOVE_UP, MOVE_DN.
- IDLE: up_stb&!dn_stb and !at_top -> MOVE_UP; dn_stb&!up_stb and !at_bottom -> MOVE_DN; remaining=STEP, divider=0. Both strobes high, or strobe toward a bound already reached -> ignored, stay IDLE.
- MOVE_*: divider counts 0..SLEW_DIV-1 and wraps; at divider==SLEW_DIV-1 (tick): pos moves 1 toward direction, remaining-1.
- Move ends on the tick where remaining reaches 0 or pos lands on the bound in the move direction; next state IDLE (or pending command, see Configuration).
- Strobes while MOVE_* without queue: dropped.
- Reset mid-move: glide abandoned, all state to reset values.
- Arithmetic: remaining width $clog2(STEP+1); divider width $clog2(SLEW_DIV), SLEW_DIV=1 ticks every cycle. Constraint POS_MIN<=POS_INIT<=POS_MAX<2**POS_W; pos never leaves [POS_MIN,POS_MAX].

## Timing
- Strobe sampled at edge E0 (accepted) -> moving=1 after E0.
- First pixel change at edge E0+SLEW_DIV; unsaturated move completes at E0+STEP*SLEW_DIV; moving deasserts on that same edge.
- at_top/at_bottom update on the same edge as pos.
- No back-pressure; strobes need no handshake, one cycle wide suffices.

## Configuration
- PADDLE_QUEUE_EN defined: one-deep pending register. First valid strobe (exactly one of up/dn high) during MOVE_*, including on the completion edge itself, is stored; later strobes ignored until consumed. On completion, pending command starts immediately (remaining=STEP, divider=0, moving stays 1) unless its direction is already at a bound, in which case it is discarded and state goes IDLE.
- Undefined: no pending register; only strobes sampled in IDLE start moves.

## Structure
- pong_pkg: state enum (IDLE, MOVE_UP, MOVE_DN), playfield constants (screen height, paddle height), default POS_* values shared with ball and collision logic.
- One sub-module: paddle_slew_tick (divider, clear input, one-cycle tick output, parameter SLEW_DIV).

## Test plan
Params SLEW_DIV=4, STEP=3, POS_MIN=0, POS_MAX=10, POS_INIT=5.
- Reset asserted 2 cycles -> pos=5, moving=0, at_top=0, at_bottom=0.
- up_stb at E0 -> pos 4,3,2 at E0+4,+8,+12; moving 1 from E0, 0 at E0+12.
- From pos=1, up_stb -> pos=0 at E0+4, at_top=1, moving=0 same edge; further up_stb -> no change.
- up_stb and dn_stb in same cycle from IDLE -> pos stays 5, moving stays 0.
- dn_stb at E0, up_stb at E0+5 -> with PADDLE_QUEUE_EN: pos 6,7,8 then 7,6,5 ending E0+24; without: stops at 8, E0+12.
- dn_stb at E0, reset at E0+6 -> pos=5, moving=0 after reset edge; no further steps.
